timer_control: RTL and testbench
================================

# timer_control

Upstream control stage for the countdown timer. It synchronizes and debounces three raw push-buttons (start, stop, reset). It turns button presses into the level-style `start`/`stop` controls and the one-cycle `timer_reset` pulse that the countdown stage consumes. It also watches the countdown's `alarm` and freezes the timer once it expires.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a new button level. Legal range is ≥ 2.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `btn_start_raw`, input, 1: asynchronous raw start button, active-high.
- `btn_stop_raw`, input, 1: asynchronous raw stop button, active-high.
- `btn_reset_raw`, input, 1: asynchronous raw reset button, active-high.
- `alarm_in`, input, 1: alarm from the countdown stage; already synchronous to `clk`.
- `start`, output, 1: run level to the countdown stage.
- `stop`, output, 1: hold level to the countdown stage. Keeps the count frozen while not running.
- `timer_reset`, output, 1: one-cycle reload pulse to the countdown stage.
- `state_o`, output, 2: current FSM state, for debug.

## Operation
Per-button conditioning, identical for all three buttons:
- Two-flop synchronizer (`s1`→`s2`). Both flops reset to 0.
- Debounce counter of width `$clog2(DEBOUNCE_CYCLES+1)`, plus a debounced level `db`.
- While `s2 != db`, the counter increments. On the cycle it would reach `DEBOUNCE_CYCLES`, `db` takes `s2` and the counter clears.
- While `s2 == db`, the counter clears. A bounce therefore restarts the count.
- The counter never wraps.
- The press event is the registered rising edge of `db`, lasting exactly one cycle. Releases generate no event.

FSM states, with encodings on `state_o`:
- IDLE (00): `start`=0, `stop`=0. The countdown reloads to 15.
- RUN (01): `start`=1, `stop`=0.
- PAUSE (10): `start`=0, `stop`=1.
- DONE (11): `start`=0, `stop`=1. Holds the count at 0 and keeps the alarm asserted.

Transitions are evaluated in priority order:
1. Reset press, from any state → IDLE, with `timer_reset`=1 for that one cycle.
2. RUN and `alarm_in`=1 → DONE.
3. Stop press: RUN → PAUSE. Ignored in IDLE, PAUSE and DONE.
4. Start press: IDLE → RUN and PAUSE → RUN. RUN behaviour depends on Configuration. Ignored in DONE.

Rules:
- Simultaneous events resolve by the priority above. Reset beats alarm, alarm beats stop, stop beats start.
- DONE is exited only by a reset press or `reset`.
- `alarm_in` is ignored outside RUN.
- All outputs are registered and decoded from the state register, except `timer_reset`, which is a registered pulse.

## Timing
- `reset`=1 at an edge forces the following after that edge:
  - all synchronizer flops, counters, `db` and edge registers to 0;
  - the state to IDLE;
  - `start`=0, `stop`=0, `timer_reset`=0, `state_o`=00.
- Press latency: a raw level change first sampled at edge N, and held stable, changes the outputs after edge N + `DEBOUNCE_CYCLES` + 3.
  - For `DEBOUNCE_CYCLES`=4, that is edge N+7.
- A raw pulse stable for fewer than `DEBOUNCE_CYCLES` cycles after synchronization produces no event.
- A button held through the release of `reset` produces one press event, after the normal latency measured from the first non-reset edge.
- `alarm_in` latency: `alarm_in`=1 sampled at edge N in RUN gives `start`=0, `stop`=1 after edge N.
- `timer_reset` is high for exactly one cycle per accepted reset press. A held reset button does not repeat the pulse.
- Assertion of `reset` mid-debounce discards the partial count. No event is produced.

## Configuration
- `PAUSE_TOGGLE_EN`:
  - Defined: a start press in RUN moves to PAUSE, so the start button toggles run/pause. Stop still has priority if both are pressed in the same cycle.
  - Not defined: a start press in RUN is ignored.
- All other behaviour is identical with and without the macro.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Apply `reset` for 2 cycles, then hold all buttons at 0 → `start`=0, `stop`=0, `timer_reset`=0, `state_o`=00 throughout.
- Hold `btn_start_raw`=1 from edge 10 → `start` rises after edge 17 and `state_o`=01. Then hold `btn_stop_raw` from edge 30 → `start`=0 and `stop`=1 after edge 37.
- Drive 3-cycle `btn_start_raw` pulses repeatedly, separated by 1-cycle lows → no state change, `start` stays 0.
- In RUN, pulse `alarm_in`=1 for one cycle → DONE, `stop`=1. Then press start and press stop → stays DONE. Then a reset press → one cycle of `timer_reset`=1 and IDLE.
- Assert `btn_reset_raw` and `btn_stop_raw` so both are accepted in the same cycle while in RUN → IDLE, one `timer_reset` pulse, `stop`=0.
- With `PAUSE_TOGGLE_EN` defined, a start press in RUN → PAUSE. With it undefined, the same stimulus → stays RUN.

Source files
------------

// File: rtl/timer_control.sv
// timer_control: debounces the start/stop/reset buttons and sequences IDLE/RUN/PAUSE/DONE for the countdown stage.
// Optional build macro PAUSE_TOGGLE_EN: a start press while running pauses instead of being ignored.
`default_nettype none

module timer_control #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start_raw,
    input  logic       btn_stop_raw,
    input  logic       btn_reset_raw,
    input  logic       alarm_in,
    output logic       start,
    output logic       stop,
    output logic       timer_reset,
    output logic [1:0] state_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Bit order for the per-button vectors: 0 = start, 1 = stop, 2 = reset.
    logic [2:0] raw;
    logic [2:0] press;

    assign raw = {btn_reset_raw, btn_stop_raw, btn_start_raw};

    generate
        for (genvar i = 0; i < 3; i++) begin : g_btn
            logic             s1;
            logic             s2;
            logic             db;
            logic             db_d;
            logic             evt;
            logic [CNT_W-1:0] cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s1   <= 1'b0;
                    s2   <= 1'b0;
                    db   <= 1'b0;
                    db_d <= 1'b0;
                    evt  <= 1'b0;
                    cnt  <= '0;
                end else begin
                    s1   <= raw[i];
                    s2   <= s1;
                    db_d <= db;
                    evt  <= db & ~db_d;
                    // Any return to the accepted level restarts the stability count.
                    if (s2 == db) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        db  <= s2;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end

            assign press[i] = evt;
        end
    endgenerate

    state_t state;
    state_t state_next;
    logic   timer_reset_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer_reset <= 1'b0;
        end else begin
            state       <= state_next;
            timer_reset <= timer_reset_next;
        end
    end

    always_comb begin
        state_next       = state;
        timer_reset_next = 1'b0;
        if (press[2]) begin
            state_next       = IDLE;
            timer_reset_next = 1'b1;
        end else if (state == RUN && alarm_in) begin
            state_next = DONE;
        end else if (press[1] && state == RUN) begin
            state_next = PAUSE;
        end else if (press[0]) begin
            case (state)
                IDLE:    state_next = RUN;
                PAUSE:   state_next = RUN;
`ifdef PAUSE_TOGGLE_EN
                RUN:     state_next = PAUSE;
`else
                RUN:     state_next = RUN;
`endif
                default: state_next = state;
            endcase
        end
    end

    assign start   = (state == RUN);
    assign stop    = (state == PAUSE) || (state == DONE);
    assign state_o = state;

endmodule

`default_nettype wire

// File: tb/tb_timer_control.sv
// tb_timer_control: randomized and directed stimulus compared every cycle against a window-based behavioural model.
`default_nettype none

module tb_timer_control;

    localparam int D = 4;
    localparam logic [1:0] M_IDLE = 2'b00, M_RUN = 2'b01, M_PAUSE = 2'b10, M_DONE = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start_raw = 1'b0, btn_stop_raw = 1'b0, btn_reset_raw = 1'b0;
    logic       alarm_in = 1'b0;
    logic       start, stop, timer_reset;
    logic [1:0] state_o;

    int passes = 0;
    int total  = 0;
    int ec     = 0;

    timer_control #(.DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_start_raw(btn_start_raw),
        .btn_stop_raw (btn_stop_raw),
        .btn_reset_raw(btn_reset_raw),
        .alarm_in     (alarm_in),
        .start        (start),
        .stop         (stop),
        .timer_reset  (timer_reset),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ec);
    endtask

    // Model: a button's level is accepted once the synchronized value has
    // differed from the accepted level for the last D edges in a row.
    int         hist[3][2];
    int         win[3][D];
    int         mdb[3];
    int         mrose[3];
    int         mpress[3];
    logic [1:0] mst;
    logic       mtr;

    always @(posedge clk) begin
        int raw_now[3];
        int s2;
        int all_same;
        int new_db;
        ec++;
        raw_now[0] = int'(btn_start_raw);
        raw_now[1] = int'(btn_stop_raw);
        raw_now[2] = int'(btn_reset_raw);
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                hist[i][0] = 0; hist[i][1] = 0;
                for (int k = 0; k < D; k++) win[i][k] = 0;
                mdb[i] = 0; mrose[i] = 0; mpress[i] = 0;
            end
            mst = M_IDLE;
            mtr = 1'b0;
        end else begin
            mtr = (mpress[2] != 0);
            if (mpress[2] != 0) mst = M_IDLE;
            else if (mst == M_RUN && alarm_in) mst = M_DONE;
            else if (mpress[1] != 0 && mst == M_RUN) mst = M_PAUSE;
            else if (mpress[0] != 0) begin
                if (mst == M_IDLE || mst == M_PAUSE) mst = M_RUN;
`ifdef PAUSE_TOGGLE_EN
                else if (mst == M_RUN) mst = M_PAUSE;
`endif
            end
            for (int i = 0; i < 3; i++) begin
                mpress[i] = mrose[i];
                s2 = hist[i][1];
                for (int k = D - 1; k > 0; k--) win[i][k] = win[i][k-1];
                win[i][0] = s2;
                all_same = 1;
                for (int k = 0; k < D; k++) if (win[i][k] != s2) all_same = 0;
                new_db = (all_same != 0 && s2 != mdb[i]) ? s2 : mdb[i];
                mrose[i] = (new_db == 1 && mdb[i] == 0) ? 1 : 0;
                mdb[i] = new_db;
                hist[i][1] = hist[i][0];
                hist[i][0] = raw_now[i];
            end
        end
    end

    always @(negedge clk) begin
        if (ec >= 1) begin
            check("model_state", int'(state_o), int'(mst));
            check("model_start", int'(start), int'(mst == M_RUN));
            check("model_stop", int'(stop), int'(mst == M_PAUSE || mst == M_DONE));
            check("model_timer_reset", int'(timer_reset), int'(mtr));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_edge(input int n);
        while (ec < n) @(negedge clk);
    endtask

    initial begin
        int pulses;
        wait_edge(2);
        check("reset_state", int'(state_o), 0);
        check("reset_outs", int'({start, stop, timer_reset}), 0);
        reset = 1'b0;

        wait_edge(9);
        btn_start_raw = 1'b1;
        wait_edge(16);
        check("start_before_17", int'(start), 0);
        wait_edge(17);
        check("start_at_17", int'(start), 1);
        check("run_state_17", int'(state_o), 1);

        wait_edge(29);
        btn_stop_raw = 1'b1;
        wait_edge(36);
        check("stop_before_37", int'(stop), 0);
        wait_edge(37);
        check("stop_at_37", int'(stop), 1);
        check("start_off_37", int'(start), 0);
        btn_start_raw = 1'b0;
        btn_stop_raw  = 1'b0;
        tick(10);

        // Short bounces while paused must never be accepted.
        repeat (5) begin
            btn_start_raw = 1'b1; tick(3);
            btn_start_raw = 1'b0; tick(1);
        end
        tick(10);
        check("bounce_no_start", int'(start), 0);
        check("bounce_state", int'(state_o), 2);

        btn_start_raw = 1'b1; tick(10);
        btn_start_raw = 1'b0; tick(4);
        check("resume_run", int'(state_o), 1);
        alarm_in = 1'b1; tick(1);
        alarm_in = 1'b0;
        check("alarm_done", int'(state_o), 3);
        check("alarm_stop", int'(stop), 1);
        btn_start_raw = 1'b1; tick(10);
        btn_start_raw = 1'b0; tick(4);
        btn_stop_raw = 1'b1; tick(10);
        btn_stop_raw = 1'b0; tick(4);
        check("done_sticky", int'(state_o), 3);

        pulses = 0;
        btn_reset_raw = 1'b1;
        repeat (20) begin tick(1); pulses += int'(timer_reset); end
        btn_reset_raw = 1'b0;
        check("reset_press_pulses", pulses, 1);
        check("reset_press_idle", int'(state_o), 0);
        tick(4);

        btn_start_raw = 1'b1; tick(10);
        btn_start_raw = 1'b0; tick(4);
        check("run_again", int'(state_o), 1);
        pulses = 0;
        btn_reset_raw = 1'b1;
        btn_stop_raw  = 1'b1;
        repeat (12) begin tick(1); pulses += int'(timer_reset); end
        btn_reset_raw = 1'b0;
        btn_stop_raw  = 1'b0;
        check("reset_stop_pulses", pulses, 1);
        check("reset_stop_idle", int'(state_o), 0);
        check("reset_stop_nostop", int'(stop), 0);
        tick(4);

        btn_start_raw = 1'b1; tick(10);
        btn_start_raw = 1'b0; tick(4);
        btn_start_raw = 1'b1; tick(10);
        btn_start_raw = 1'b0; tick(4);
`ifdef PAUSE_TOGGLE_EN
        check("toggle_start", int'(state_o), 2);
`else
        check("toggle_start", int'(state_o), 1);
`endif

        for (int c = 0; c < 4000; c++) begin
            tick(1);
            if ($urandom_range(0, 7) == 0) btn_start_raw = ~btn_start_raw;
            if ($urandom_range(0, 9) == 0) btn_stop_raw  = ~btn_stop_raw;
            if ($urandom_range(0, 29) == 0) btn_reset_raw = ~btn_reset_raw;
            alarm_in = ($urandom_range(0, 24) == 0);
            reset    = ($urandom_range(0, 399) == 0);
        end
        reset = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

`default_nettype wire
